// File: rtl/serial_alu_multi.sv
// Digit-serial ALU over a small register file: operands span 1..MAX_BYTES
// consecutive registers, processed LSB digit first, NSHIFT bits per cycle.
module serial_alu_multi #(
    parameter int LOG2_NR   = 3,
    parameter int REG_BITS  = 8,
    parameter int NSHIFT    = 2,
    parameter int MAX_BYTES = 4,
    localparam int LW = $clog2(MAX_BYTES),
    localparam int CW = $clog2(MAX_BYTES * REG_BITS / NSHIFT)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               op_valid,
    input  logic [3:0]         operation,
    input  logic [LW-1:0]      len_m1,
    input  logic [LOG2_NR-1:0] reg1,
    input  logic [LOG2_NR-1:0] reg2,
    input  logic               external_arg2,
    input  logic [NSHIFT-1:0]  data_in,
    output logic [NSHIFT-1:0]  data_out,
    output logic               op_done,
    output logic [CW-1:0]      counter,
    output logic               flag_c,
    output logic               flag_v,
    output logic               flag_s,
    output logic               flag_z
);
    localparam int NR  = 1 << LOG2_NR;
    localparam int DPR = REG_BITS / NSHIFT;
    localparam int BW  = $clog2(REG_BITS);
    localparam int NW  = NSHIFT + 1;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0, OP_SUB = 4'd1, OP_ADC = 4'd2, OP_SBC = 4'd3,
        OP_AND = 4'd4, OP_OR  = 4'd5, OP_XOR = 4'd6, OP_MOV = 4'd7,
        OP_CMP = 4'd8, OP_SHL = 4'd9, OP_RCL = 4'd10
    } op_e;

    op_e                 op;
    logic [REG_BITS-1:0] regs [NR];
    logic [CW-1:0]       last, byte_idx, digit_idx;
    logic [BW-1:0]       bit_off;
    logic [LOG2_NR-1:0]  addr1, addr2;
    logic [NSHIFT-1:0]   a1, a2, a2e, result;
    logic [NW-1:0]       sum, shl;
    logic                is_sub, seed, cin, cout, carry_q, z_q, z_acc, ovf, wr_en;

    always_comb begin
        op        = op_e'(operation);
        last      = CW'((32'(len_m1) + 1) * DPR - 1);
        byte_idx  = counter / CW'(DPR);
        digit_idx = counter % CW'(DPR);
        bit_off   = BW'(32'(digit_idx) * NSHIFT);
        addr1     = reg1 + LOG2_NR'(byte_idx);
        addr2     = reg2 + LOG2_NR'(byte_idx);
        a1        = regs[addr1][bit_off +: NSHIFT];
        a2        = external_arg2 ? data_in : regs[addr2][bit_off +: NSHIFT];

        is_sub = op inside {OP_SUB, OP_SBC, OP_CMP};
        case (op)
            OP_SUB, OP_CMP:         seed = 1'b1;
            OP_ADC, OP_SBC, OP_RCL: seed = flag_c;
            default:                seed = 1'b0;
        endcase
        // Digit 0 takes the opcode's seed; later digits take the rippled carry.
        cin  = (counter == '0) ? seed : carry_q;
        a2e  = is_sub ? ~a2 : a2;
        sum  = {1'b0, a1} + {1'b0, a2e} + NW'(cin);
        shl  = {a1, cin};

        result = sum[NSHIFT-1:0];
        cout   = sum[NSHIFT];
        case (op)
            OP_AND: result = a1 & a2;
            OP_OR:  result = a1 | a2;
            OP_XOR: result = a1 ^ a2;
            OP_MOV: result = a2;
            OP_SHL, OP_RCL: begin
                result = shl[NSHIFT-1:0];
                cout   = shl[NSHIFT];
            end
            default: ;
        endcase

        ovf   = (a1[NSHIFT-1] == a2e[NSHIFT-1]) && (result[NSHIFT-1] != a1[NSHIFT-1]);
        z_acc = ((counter == '0) || z_q) && (result == '0);
        wr_en = op_valid && !reset &&
                (op <= OP_MOV || op == OP_SHL || op == OP_RCL);
    end

    assign data_out = result;
    assign op_done  = op_valid && (counter == last);

    always_ff @(posedge clk) begin
        if (wr_en)
            regs[addr1][bit_off +: NSHIFT] <= result;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            counter <= '0;
            carry_q <= 1'b0;
            z_q     <= 1'b1;
            flag_c  <= 1'b0;
            flag_v  <= 1'b0;
            flag_s  <= 1'b0;
            flag_z  <= 1'b0;
        end else if (op_valid) begin
            counter <= op_done ? '0 : counter + CW'(1);
            carry_q <= cout;
            z_q     <= z_acc;
            if (op_done) begin
                case (op)
                    OP_ADD, OP_SUB, OP_ADC, OP_SBC, OP_CMP: begin
                        flag_c <= cout;
                        flag_v <= ovf;
                        flag_s <= result[NSHIFT-1];
                        flag_z <= z_acc;
                    end
                    OP_AND, OP_OR, OP_XOR: begin
                        flag_s <= result[NSHIFT-1];
                        flag_z <= z_acc;
                    end
                    OP_SHL, OP_RCL: begin
                        flag_c <= cout;
                        flag_v <= result[NSHIFT-1] ^ cout;
                        flag_s <= result[NSHIFT-1];
                        flag_z <= z_acc;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_serial_alu_multi.sv
// Scoreboard bench: a byte-level register/flag model predicts each op; a
// monitor reassembles the serial data_out stream and checks it with the flags.
module tb_serial_alu_multi #(
    parameter int NSHIFT    = 2,
    parameter int MAX_BYTES = 4
);
    localparam int LOG2_NR = 3;
    localparam int REG_BITS = 8;
    localparam int NR   = 8;
    localparam int LW   = $clog2(MAX_BYTES);
    localparam int CW   = $clog2(MAX_BYTES * REG_BITS / NSHIFT);
    localparam int DPR  = REG_BITS / NSHIFT;
    localparam int LMAX = MAX_BYTES - 1;

    logic clk = 1'b0, reset = 1'b1, op_valid = 1'b0, external_arg2 = 1'b0;
    logic [3:0] operation = '0;
    logic [LW-1:0] len_m1 = '0;
    logic [LOG2_NR-1:0] reg1 = '0, reg2 = '0;
    logic [NSHIFT-1:0] data_in = '0, data_out;
    logic op_done, flag_c, flag_v, flag_s, flag_z;
    logic [CW-1:0] counter;

    serial_alu_multi #(.LOG2_NR(LOG2_NR), .REG_BITS(REG_BITS), .NSHIFT(NSHIFT),
                       .MAX_BYTES(MAX_BYTES)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .operation(operation),
        .len_m1(len_m1), .reg1(reg1), .reg2(reg2), .external_arg2(external_arg2),
        .data_in(data_in), .data_out(data_out), .op_done(op_done), .counter(counter),
        .flag_c(flag_c), .flag_v(flag_v), .flag_s(flag_s), .flag_z(flag_z));

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        bit          chk_res;
        int          cycles;
        bit          c, v, s, z;
    } exp_t;

    exp_t sb[$];
    int total = 0, bad = 0;
    logic [7:0] mregs [NR];
    bit mc = 0, mv = 0, ms = 0, mz = 0;
    bit flag_pend = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Whole-byte reference: reads see bytes written earlier in the same op.
    function automatic exp_t model(input int op, input int lm1, input int r1, input int r2,
                                   input bit ext, input logic [31:0] ev);
        exp_t e;
        int c, a1, a2, a2e, res, s, ta1, ta2e, tres;
        bit wr;
        logic [7:0] evb;
        e.res = 0; e.cycles = (lm1 + 1) * DPR; e.chk_res = (op < 11);
        wr = (op <= 7) || op == 9 || op == 10;
        case (op)
            1, 8:     c = 1;
            2, 3, 10: c = int'(mc);
            default:  c = 0;
        endcase
        ta1 = 0; ta2e = 0; tres = 0;
        for (int k = 0; k <= lm1; k++) begin
            evb = ev[8*k +: 8];
            a1  = int'(mregs[(r1 + k) % NR]);
            a2  = ext ? int'(evb) : int'(mregs[(r2 + k) % NR]);
            a2e = (op == 1 || op == 3 || op == 8) ? (~a2 & 255) : a2;
            case (op)
                4: res = a1 & a2;
                5: res = a1 | a2;
                6: res = a1 ^ a2;
                7: res = a2;
                9, 10: begin s = a1 * 2 + c; res = s & 255; c = a1 >> 7; end
                default: begin s = a1 + a2e + c; res = s & 255; c = s >> 8; end
            endcase
            if (wr) mregs[(r1 + k) % NR] = res[7:0];
            e.res = e.res | (32'(res) << (8 * k));
            ta1 = a1; ta2e = a2e; tres = res;
        end
        if (op <= 3 || op == 8) begin
            mc = c[0];
            mv = ((ta1 >> 7) == (ta2e >> 7)) && ((tres >> 7) != (ta1 >> 7));
            ms = tres[7]; mz = (e.res == 0);
        end else if (op >= 4 && op <= 6) begin
            ms = tres[7]; mz = (e.res == 0);
        end else if (op == 9 || op == 10) begin
            mc = c[0]; ms = tres[7]; mz = (e.res == 0); mv = ms ^ mc;
        end
        e.c = mc; e.v = mv; e.s = ms; e.z = mz;
        return e;
    endfunction

    task automatic run_op(input int op, input int lm1, input int r1, input int r2,
                          input bit ext, input logic [31:0] ev);
        exp_t e;
        e = model(op, lm1, r1, r2, ext, ev);
        sb.push_back(e);
        operation = 4'(op); len_m1 = LW'(lm1); reg1 = 3'(r1); reg2 = 3'(r2);
        external_arg2 = ext; op_valid = 1'b1;
        for (int i = 0; i < e.cycles; i++) begin
            data_in = ev[i*NSHIFT +: NSHIFT];
            @(posedge clk); #1;
        end
        op_valid = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    endtask

    // Monitor: one digit per active cycle; flags checked the cycle after op_done.
    initial begin
        logic [31:0] acc;
        int cnt;
        exp_t e, fe;
        acc = 0; cnt = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                acc = 0; cnt = 0; flag_pend = 0;
            end else begin
                if (flag_pend) begin
                    check("flag_c", flag_c, fe.c);
                    check("flag_v", flag_v, fe.v);
                    check("flag_s", flag_s, fe.s);
                    check("flag_z", flag_z, fe.z);
                    flag_pend = 0;
                end
                if (op_valid) begin
                    check("counter", counter, cnt);
                    acc = acc | (32'(data_out) << (cnt * NSHIFT));
                    cnt++;
                    if (op_done) begin
                        if (sb.size() == 0) begin
                            check("spurious_done", 1, 0);
                        end else begin
                            e = sb.pop_front();
                            check("cycles", cnt, e.cycles);
                            if (e.chk_res) check("result", acc, e.res);
                            fe = e; flag_pend = 1;
                        end
                        acc = 0; cnt = 0;
                    end
                end
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_counter", counter, 0);
        check("rst_done", op_done, 0);
        check("rst_flags", {flag_c, flag_v, flag_s, flag_z}, 0);

        for (int r = 0; r < NR; r++) run_op(7, 0, r, 0, 1, 32'($urandom_range(0, 255)));

        run_op(7, 1, 0, 0, 1, 32'h12FF);          // load r1:r0
        run_op(0, 1, 0, 0, 1, 32'h0001);          // -> 0x1300
        run_op(7, LMAX, 0, 0, 1, 32'hFFFF_FFFF);
        run_op(0, LMAX, 0, 0, 1, 32'h1);          // wrap to zero, C=1 Z=1

        // Abort a NOP after 3 digits; flags were left non-zero by the wrap.
        operation = 4'd11; len_m1 = LW'(LMAX); external_arg2 = 1'b1; op_valid = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        op_valid = 1'b0; reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        mc = 0; mv = 0; ms = 0; mz = 0;
        check("abort_counter", counter, 0);
        check("abort_flags", {flag_c, flag_v, flag_s, flag_z}, 0);
        run_op(4, LMAX, 0, 0, 1, 32'hFFFF_FFFF); // full length after reset

        run_op(7, 0, 0, 0, 1, 32'h80);
        run_op(1, 0, 0, 0, 1, 32'h01);            // 0x7F, C=1 V=1
        run_op(8, 0, 0, 0, 0, 32'h0);             // CMP r0,r0
        run_op(5, 0, 0, 0, 1, 32'h0);             // readback r0
        run_op(7, 0, 2, 0, 1, 32'h0);
        run_op(0, 0, 2, 0, 1, 32'h0);             // clear C
        run_op(7, 0, 0, 0, 1, 32'h05);
        run_op(3, 0, 0, 0, 1, 32'h05);            // 0xFF, C=0 S=1
        run_op(7, 0, 0, 0, 1, 32'h81);
        run_op(9, 0, 0, 0, 1, 32'h0);             // SHL -> 0x02 C=1 V=1
        run_op(7, 0, 1, 0, 1, 32'h40);
        run_op(10, 0, 1, 0, 1, 32'h0);            // RCL -> 0x81 C=0 S=1 V=1
        run_op(7, 0, 3, 0, 1, 32'hA5);
        run_op(7, 1, 4, 3, 0, 32'h0);             // r4<=r3, r5<=r4 (propagates)
        run_op(5, 0, 5, 0, 1, 32'h0);             // readback r5
        run_op(7, 1, 7, 0, 1, 32'hBEEF);          // wraps r7 -> r0
        run_op(5, 0, 0, 0, 1, 32'h0);

        for (int n = 0; n < 60; n++)
            run_op($urandom_range(0, 15), $urandom_range(0, LMAX), $urandom_range(0, 7),
                   $urandom_range(0, 7), 1'($urandom_range(0, 1)), $urandom);

        for (int i = 0; i < 100 && (sb.size() != 0 || flag_pend); i++) @(posedge clk);
        #1 check("drain", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
